uart_tx_fifo: RTL and testbench

//  UART 8N1 transmitter with an input byte FIFO; the return path of the host link, driving top-level uart_txd.

---
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// Bytes pushed with a valid/ready handshake are serialised LSB-first.
// A new frame starts directly from the stop bit when more data is queued,
// so back-to-back bytes leave with no idle gap.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int BAUD_DIV   = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             uart_txd,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          fifo_nempty;

    // Full is decoded from the registered count, so a pop in the same cycle
    // never frees a slot for a simultaneous push.
    assign tx_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign fifo_nempty = (fifo_count != '0);
    assign push        = tx_valid && tx_ready;
    assign bit_end     = (baud_cnt == BW'(BAUD_DIV - 1));

    // Pop from IDLE, or from the final stop-bit cycle to chain frames gap-free.
    always_comb begin
        pop = 1'b0;
        if (fifo_nempty) begin
            if (state == ST_IDLE)
                pop = 1'b1;
            else if (state == ST_STOP && bit_end)
                pop = 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate validity.
    always_ff @(posedge sys_clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Frame sequencer: baud counter restarts every bit and is held in IDLE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7)
                            state <= ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered line outputs; they trail the sequencer by one cycle, which
    // shifts the whole frame uniformly and keeps bit widths exact.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            case (state)
                ST_START: uart_txd <= 1'b0;
                ST_DATA:  uart_txd <= shift[0];
                default:  uart_txd <= 1'b1;
            endcase
            tx_busy <= (state != ST_IDLE);
            tx_done <= (state == ST_STOP) && bit_end;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a mid-bit sampling
// UART receiver. Baud is raised so that a bit is 20 clocks.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 2_500_000;
    localparam int DIV       = 20;
    localparam int FRAME     = 10 * DIV;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 5;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [7:0]       tx_data   = 8'h00;
    logic             tx_valid  = 1'b0;
    logic             tx_ready;
    logic             uart_txd;
    logic             tx_busy;
    logic             tx_done;
    logic [CNT_W-1:0] fifo_count;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    bit         rx_en = 1'b0;

    uart_tx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_txd  (uart_txd),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .fifo_count(fifo_count)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the byte is accepted.
    task automatic push(input logic [7:0] b);
        int t = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && t < 5000) begin
            @(negedge sys_clk);
            t++;
        end
        if (!tx_ready) chk("push_timeout", 32'd0, 32'd1);
        else exp_q.push_back(b);
        @(negedge sys_clk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge sys_clk);
            t++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (DIV) @(negedge sys_clk);
    endtask

    // Entered on the negedge of frame cycle 1; checks every line cycle.
    task automatic watch(input string tag, input int nf, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] bs [3];
        int bad = 0, busy_bad = 0, dn = 0, dn_bad = 0;
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        for (int c = 1; c <= nf * FRAME; c++) begin
            int f, bi;
            logic e;
            f  = (c - 1) / FRAME;
            bi = ((c - 1) % FRAME) / DIV;
            e  = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : bs[f][bi-1];
            if (uart_txd !== e) bad++;
            if (tx_busy !== 1'b1) busy_bad++;
            if (tx_done === 1'b1) begin
                dn++;
                if (c % FRAME != 0) dn_bad++;
            end
            @(negedge sys_clk);
        end
        chk({tag, "_line"}, 32'(bad), 32'd0);
        chk({tag, "_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_done_cnt"}, 32'(dn), 32'(nf));
        chk({tag, "_done_pos"}, 32'(dn_bad), 32'd0);
        chk({tag, "_end_txd"}, 32'(uart_txd), 32'd1);
        chk({tag, "_end_busy"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic rx_wait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge sys_clk);
            if (!sys_rst_n) ab = 1'b1;
        end
    endtask

    // Bench receiver: samples each bit at its midpoint, checks the scoreboard.
    initial begin : rx
        forever begin
            @(negedge sys_clk);
            if (rx_en && sys_rst_n && uart_txd === 1'b0) begin
                bit ab;
                logic [7:0] d;
                ab = 1'b0;
                d  = 8'h00;
                rx_wait(DIV / 2 - 1, ab);
                if (!ab) chk("rx_start", 32'(uart_txd), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    rx_wait(DIV, ab);
                    d[i] = uart_txd;
                end
                rx_wait(DIV, ab);
                if (!ab) begin
                    chk("rx_stop", 32'(uart_txd), 32'd1);
                    if (exp_q.size() == 0) chk("rx_unexpected", 32'(d), 32'hFFFF_FFFF);
                    else chk("rx_byte", 32'(d), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : main
        int acc, first_stall, inv_bad, max_cnt, t, rdy_bad, bad, dn;

        // 1: reset values, then long idle
        #25;
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        rx_en     = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1 ||
                fifo_count !== '0 || tx_done !== 1'b0) bad++;
        end
        chk("idle_1000", 32'(bad), 32'd0);

        // 2: single byte, latency and frame shape
        push(8'hA5);
        tx_valid = 1'b0;
        chk("lat_cnt_k", 32'(fifo_count), 32'd1);
        chk("lat_txd_k", 32'(uart_txd), 32'd1);
        @(negedge sys_clk);
        chk("lat_cnt_k1", 32'(fifo_count), 32'd0);
        chk("lat_txd_k1", 32'(uart_txd), 32'd1);
        @(negedge sys_clk);
        chk("lat_txd_k2", 32'(uart_txd), 32'd0);
        watch("a5", 1, 8'hA5, 8'h00, 8'h00);
        drain();

        // 3: three back-to-back frames with no gap
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        tx_valid = 1'b0;
        chk("b2b_fall", 32'(uart_txd), 32'd0);
        watch("b2b", 3, 8'h00, 8'hFF, 8'h55);
        drain();

        // 4: hold valid with 20 bytes; FIFO fills and back-pressures
        acc = 0; first_stall = -1; inv_bad = 0; max_cnt = 0; t = 0;
        tx_valid = 1'b1;
        tx_data  = 8'h30;
        while (acc < 20 && t < 20000) begin
            if ((tx_ready === 1'b1) != (fifo_count != CNT_W'(DEPTH))) inv_bad++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (tx_ready) begin
                exp_q.push_back(tx_data);
                acc++;
            end else if (first_stall < 0) begin
                first_stall = acc;
            end
            @(negedge sys_clk);
            t++;
            tx_data = 8'(8'h30 + acc);
        end
        tx_valid = 1'b0;
        chk("full_first_stall", 32'(first_stall), 32'd17);
        chk("full_ready_decode", 32'(inv_bad), 32'd0);
        chk("full_max_cnt", 32'(max_cnt), 32'(DEPTH));
        chk("full_accepted", 32'(acc), 32'd20);
        drain();

        // 5: push attempt while full coincides with a pop
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + i));
        chk("p5_full_cnt", 32'(fifo_count), 32'(DEPTH));
        chk("p5_full_ready", 32'(tx_ready), 32'd0);
        tx_data = 8'hEE;
        rdy_bad = 0; t = 0;
        while (tx_done !== 1'b1 && t < 2 * FRAME) begin
            if (tx_ready !== 1'b0) rdy_bad++;
            @(negedge sys_clk);
            t++;
        end
        chk("p5_ready_low", 32'(rdy_bad), 32'd0);
        chk("p5_pop_cnt", 32'(fifo_count), 32'd15);
        chk("p5_ready_rise", 32'(tx_ready), 32'd1);
        exp_q.push_back(8'hEE);
        @(negedge sys_clk);
        tx_valid = 1'b0;
        chk("p5_refill_cnt", 32'(fifo_count), 32'(DEPTH));
        drain();

        // 6: async reset in data bit 3 with five bytes queued
        push(8'hF7);
        tx_valid = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        tx_valid = 1'b0;
        repeat (4 * DIV + DIV / 2 - 6) @(negedge sys_clk);
        chk("rst6_pre_txd", 32'(uart_txd), 32'd0);
        chk("rst6_pre_cnt", 32'(fifo_count), 32'd5);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("rst6_txd", 32'(uart_txd), 32'd1);
        chk("rst6_cnt", 32'(fifo_count), 32'd0);
        chk("rst6_busy", 32'(tx_busy), 32'd0);
        chk("rst6_ready", 32'(tx_ready), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0; dn = 0;
        repeat (3 * FRAME) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
            if (tx_done === 1'b1) dn++;
        end
        chk("rst6_post_idle", 32'(bad), 32'd0);
        chk("rst6_post_done", 32'(dn), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
